cin_burst_gen: RTL and testbench
================================

# cin_burst_gen

Synthesizable generator of single-cycle enable strobes that drives the `cin` input of the 4-bit counter IP. It replaces hand-written testbench stimulus with an on-chip sequencer so the counter can be exercised and demonstrated in hardware. A start request launches a burst of N strobes spaced P clocks apart. Busy, done and sent-count outputs let downstream logic check the counter's `q`/`cout` against the number of strobes issued.

## Interface
- `CNT_W`, default 8: width of the burst-length input and the sent-count output.
- `PER_W`, default 8: width of the strobe-period input.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  burst request. Sampled only in IDLE.
- `abort`  in  1  terminates a running burst. Ignored in IDLE.
- `burst_len`  in  CNT_W  strobe count N, latched on an accepted start.
- `period`  in  PER_W  strobe spacing P in clocks, latched on an accepted start.
- `cin`  out  1  strobe to the counter. Registered, one cycle wide.
- `busy`  out  1  high while a burst is running.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `sent`  out  CNT_W  strobes issued since the last accepted start.

## Operation
- State machine:
  - IDLE → RUN on `start`=1 when N≠0.
  - IDLE → IDLE on `start`=1 when N=0; `done` pulses.
  - RUN → IDLE after the final strobe, or on `abort`.
- Accepted start:
  - latches N and P;
  - clears `sent` to 0;
  - loads the period timer.
- Period rule: P=0 and P=1 both mean one strobe every clock. Effective period Pe = max(P,1).
- RUN:
  - a down-timer reloads to Pe-1 after each strobe;
  - a strobe is issued when the timer reaches 0;
  - `sent` increments by 1 on the same edge that raises `cin`;
  - the remaining-strobe counter decrements on each strobe;
  - when it reaches 0 the FSM exits to IDLE.
- `start` while busy is ignored and the latched N/P are unaffected. `burst_len`/`period` may change freely during RUN.
- Abort:
  - `abort`=1 in RUN forces `cin`=0 and `busy`=0 on the next edge;
  - returns to IDLE;
  - `done` is not asserted;
  - `sent` holds its value;
  - `start` and `abort` high together in IDLE: `abort` is ignored and `start` is accepted.
- `abort` and the final-strobe edge in the same cycle: the strobe still issues and abort wins, so no `done` pulse.
- `sent` saturates at neither end; N ≤ 2^CNT_W-1, so it cannot wrap.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `cin`=0, `busy`=0, `done`=0, `sent`=0, internal timers 0. This takes effect at that edge regardless of state, including mid-burst. No strobe or `done` follows the reset.
- Start sampled at edge k with N≥1:
  - `busy`=1 from edge k.
  - Strobe i (i = 0..N-1) has `cin`=1 in the cycle after edge k+i·Pe.
  - The first strobe has 1-cycle latency.
  - `sent` = i+1 from edge k+i·Pe.
  - `done`=1 and `busy`=0 in the cycle after edge k+(N-1)·Pe+1.
- Start at edge k with N=0: `done`=1 in the cycle after edge k; `busy` stays 0; `cin` stays 0; `sent`=0.
- A new start is accepted earliest in the cycle where `done`=1. Back-to-back bursts are therefore separated by at least one idle strobe slot.
- With Pe=1, `cin` is high for N consecutive cycles; this is the only case where `cin` exceeds one cycle.

## Test plan
- N=3, P=4, start at edge 10:
  - `cin` high after edges 10, 14, 18;
  - `sent` = 1/2/3;
  - `done` after edge 19;
  - the attached counter reads `q`=3.
- N=0, then P=0 with N=5:
  - first run: a single `done` pulse, no `cin`, `busy` never high;
  - second run: `cin` high for 5 consecutive cycles, `sent`=5.
- N=20, P=2 (matches manual counter stimulus):
  - 20 strobes;
  - counter `cout` seen once at `q`=15;
  - final `q`=4.
- Start re-pulsed at edges 12 and 13 during an N=4, P=3 burst started at edge 10: burst timing unchanged, exactly 4 strobes, one `done`.
- Abort after the 2nd strobe of N=6, P=5: `busy` drops the next cycle, no further `cin`, no `done`, `sent` holds 2.
- `rst_n`=0 mid-burst (N=8, P=3, after 3 strobes): all outputs 0 at the reset edge. After release, start N=1 gives one strobe with `sent`=1.

Source files
------------

// File: rtl/cin_burst_gen_if.sv
// Request/status bundle between a burst requester and cin_burst_gen.
// The requester drives start/abort/length/period; the generator drives the
// strobe and its status.
interface cin_burst_gen_if #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] burst_len;
    logic [PER_W-1:0] period;
    logic             cin;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    modport master (
        output start, abort, burst_len, period,
        input  cin, busy, done, sent
    );

    modport slave (
        input  start, abort, burst_len, period,
        output cin, busy, done, sent
    );
endinterface

// File: rtl/cin_burst_gen.sv
// cin_burst_gen: issues a burst of N single-cycle strobes spaced P clocks
// apart on the counter enable. The first strobe rises on the same edge that
// accepts the start. busy/done/sent report progress.
module cin_burst_gen #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
) (
    input  logic           clock,
    input  logic           rst_n,
    cin_burst_gen_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [PER_W-1:0] timer_q,  timer_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] sent_q,   sent_d;
    logic             cin_q,    cin_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             strobe_due_s;
    logic             last_strobe_s;

    // Timer reload value Pe-1, where P=0 and P=1 both mean every clock.
    function automatic logic [PER_W-1:0] reload_val(input logic [PER_W-1:0] p);
        if (p == {PER_W{1'b0}}) begin
            reload_val = {PER_W{1'b0}};
        end else begin
            reload_val = p - PER_W'(1);
        end
    endfunction

    // Next-state, strobe and status decode.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        period_d      = period_q;
        remain_d      = remain_q;
        sent_d        = sent_q;
        cin_d         = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        strobe_due_s  = (timer_q == {PER_W{1'b0}}) && (remain_q != {CNT_W{1'b0}});
        last_strobe_s = strobe_due_s && (remain_q == CNT_W'(1));

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    period_d = bus.period;
                    timer_d  = reload_val(bus.period);
                    if (bus.burst_len != {CNT_W{1'b0}}) begin
                        // Strobe 0 goes out on the accepting edge.
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        cin_d    = 1'b1;
                        sent_d   = CNT_W'(1);
                        remain_d = bus.burst_len - CNT_W'(1);
                    end else begin
                        // Empty burst completes immediately.
                        sent_d   = {CNT_W{1'b0}};
                        remain_d = {CNT_W{1'b0}};
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    // Abort ends the burst without done; a final strobe
                    // falling on the same edge is still issued.
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    timer_d  = {PER_W{1'b0}};
                    remain_d = {CNT_W{1'b0}};
                    if (last_strobe_s) begin
                        cin_d  = 1'b1;
                        sent_d = sent_q + CNT_W'(1);
                    end else begin
                        cin_d  = 1'b0;
                    end
                end else if (remain_q == {CNT_W{1'b0}}) begin
                    // Final strobe was issued on the previous edge.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    timer_d = {PER_W{1'b0}};
                end else if (timer_q == {PER_W{1'b0}}) begin
                    cin_d    = 1'b1;
                    sent_d   = sent_q + CNT_W'(1);
                    remain_d = remain_q - CNT_W'(1);
                    timer_d  = reload_val(period_q);
                end else begin
                    timer_d  = timer_q - PER_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                timer_d  = {PER_W{1'b0}};
                remain_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= {PER_W{1'b0}};
            period_q <= {PER_W{1'b0}};
            remain_q <= {CNT_W{1'b0}};
            sent_q   <= {CNT_W{1'b0}};
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            remain_q <= remain_d;
            sent_q   <= sent_d;
            cin_q    <= cin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cin  = cin_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sent = sent_q;

endmodule

// File: tb/tb_cin_burst_gen.sv
// Directed bench for cin_burst_gen with a behavioural 4-bit counter on cin.
module tb_cin_burst_gen;

    logic clock;
    logic rst_n;
    logic cnt_clr;
    logic [3:0] q;
    int   cout_cnt;
    int   n_checks;
    int   n_fail;
    logic [63:0] mask;

    cin_burst_gen_if #(.CNT_W(8), .PER_W(8)) bus_if ();

    cin_burst_gen #(.CNT_W(8), .PER_W(8)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached 4-bit counter: counts cin strobes, cout when wrapping from 15.
    always_ff @(posedge clock) begin
        if (cnt_clr) begin
            q        <= 4'd0;
            cout_cnt <= 0;
        end else if (bus_if.cin === 1'b1) begin
            q <= q + 4'd1;
            if (q == 4'd15) cout_cnt <= cout_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int sent_e);
        chk({tag, "_cin"},  32'(bus_if.cin),  32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus_if.done), 32'd0);
        chk({tag, "_sent"}, 32'(bus_if.sent), 32'(sent_e));
    endtask

    // Called just after the accepting edge k (t=0); checks t=0..cycles using
    // the documented timing and drives start from smask between edges.
    task automatic expect_burst(input int n, input int pe, input int cycles,
                                input logic [63:0] smask);
        int k, sent_e;
        logic cin_e, busy_e, done_e;
        for (int t = 0; t <= cycles; t++) begin
            if (n == 0) begin
                cin_e = 1'b0; busy_e = 1'b0; done_e = (t == 0); sent_e = 0;
            end else begin
                k      = t / pe;
                cin_e  = ((t % pe) == 0) && (k < n);
                sent_e = (k + 1 < n) ? k + 1 : n;
                busy_e = (t <= (n - 1) * pe);
                done_e = (t == (n - 1) * pe + 1);
            end
            chk($sformatf("n%0d_p%0d_t%0d_cin",  n, pe, t), 32'(bus_if.cin),  32'(cin_e));
            chk($sformatf("n%0d_p%0d_t%0d_busy", n, pe, t), 32'(bus_if.busy), 32'(busy_e));
            chk($sformatf("n%0d_p%0d_t%0d_done", n, pe, t), 32'(bus_if.done), 32'(done_e));
            chk($sformatf("n%0d_p%0d_t%0d_sent", n, pe, t), 32'(bus_if.sent), 32'(sent_e));
            if (t < cycles) begin
                bus_if.start = smask[t + 1];
                tick();
            end
        end
        bus_if.start = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic launch(input int n, input int p);
        bus_if.burst_len = 8'(n);
        bus_if.period    = 8'(p);
        bus_if.start     = 1'b1;
        tick();
        bus_if.start     = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        cnt_clr  = 1'b1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.burst_len = 8'd0;
        bus_if.period    = 8'd0;
        tick();
        tick();
        chk_idle("reset", 0);
        rst_n   = 1'b1;
        cnt_clr = 1'b0;
        tick();

        // N=3, P=4: strobes at t=0,4,8, done at t=9.
        launch(3, 4);
        expect_burst(3, 4, 12, 64'd0);
        chk("n3_q", 32'(q), 32'd3);

        // N=0: lone done pulse; then P=0 with N=5: five back-to-back strobes.
        clr_cnt();
        launch(0, 7);
        expect_burst(0, 1, 4, 64'd0);
        chk("n0_q", 32'(q), 32'd0);
        launch(5, 0);
        expect_burst(5, 1, 8, 64'd0);
        chk("p0_q", 32'(q), 32'd5);

        // N=20, P=2: counter wraps once, ends at 4.
        clr_cnt();
        launch(20, 2);
        expect_burst(20, 2, 42, 64'd0);
        chk("n20_q", 32'(q), 32'd4);
        chk("n20_cout", 32'(cout_cnt), 32'd1);

        // N=4, P=3 with start re-pulsed at t=2,3 and inputs changed mid-burst.
        clr_cnt();
        launch(4, 3);
        bus_if.burst_len = 8'd9;
        bus_if.period    = 8'd1;
        mask = 64'd0;
        mask[2] = 1'b1;
        mask[3] = 1'b1;
        expect_burst(4, 3, 13, mask);
        chk("repulse_q", 32'(q), 32'd4);

        // Abort after the 2nd strobe of N=6, P=5.
        clr_cnt();
        launch(6, 5);
        expect_burst(6, 5, 5, 64'd0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        chk_idle("abort_edge", 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle($sformatf("abort_after%0d", i), 2);
        end
        chk("abort_q", 32'(q), 32'd2);

        // Abort coinciding with the final strobe: strobe issues, no done.
        clr_cnt();
        launch(2, 3);
        expect_burst(2, 3, 2, 64'd0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        chk("lastab_cin",  32'(bus_if.cin),  32'd1);
        chk("lastab_busy", 32'(bus_if.busy), 32'd0);
        chk("lastab_done", 32'(bus_if.done), 32'd0);
        chk("lastab_sent", 32'(bus_if.sent), 32'd2);
        tick();
        chk_idle("lastab_next", 2);
        chk("lastab_q", 32'(q), 32'd2);

        // start and abort together in IDLE: start wins.
        bus_if.abort = 1'b1;
        launch(1, 0);
        bus_if.abort = 1'b0;
        expect_burst(1, 1, 3, 64'd0);

        // Reset mid-burst after 3 strobes of N=8, P=3.
        clr_cnt();
        launch(8, 3);
        expect_burst(8, 3, 7, 64'd0);
        rst_n = 1'b0;
        tick();
        chk_idle("midrst", 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle($sformatf("postrst%0d", i), 0);
        end
        chk("midrst_q", 32'(q), 32'd3);
        launch(1, 2);
        expect_burst(1, 2, 3, 64'd0);
        chk("postrst_q", 32'(q), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
